// File: rtl/dma_rd_sgl_scheduler.sv
// Purpose : walks the BRAM scatter-gather list and issues PCIe memory-read requests,
//           split at max-read-request size and 4 KB boundaries, with rotating tags.
// Latency : request valid the cycle after LOAD; next entry loaded ENTRY_LAT cycles after next_entry.
// Backpr. : rd_req_valid/rd_req_ready handshake; valid held low while NUM_TAGS reads are in flight.
//
// Ports:
//   trn_clk, trn_reset_n          clock, asynchronous active-low reset
//   start, abort                  control pulses (start only honoured in IDLE)
//   sgl_ready, sgl_dma_addr/len,  current SGL entry from the loader
//   last_entry, next_entry        next_entry pulses to advance the loader read pointer
//   dma_en, done                  walk active / one-cycle completion pulse
//   rd_req_*                      read request towards the TRN TX formatter
//   cpl_done, cpl_tag             final completion for a tag has arrived
//   outstanding                   number of reads currently in flight
module dma_rd_sgl_scheduler #(
    parameter int          MRRS_DW   = 128,
    parameter logic [7:0]  TAG_BASE  = 8'h10,
    parameter int          NUM_TAGS  = 8,
    parameter int          ENTRY_LAT = 3
) (
    input  logic        trn_clk,
    input  logic        trn_reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        sgl_ready,
    input  logic [39:0] sgl_dma_addr,
    input  logic [9:0]  sgl_dma_len,
    input  logic        last_entry,
    output logic        next_entry,
    output logic        dma_en,
    output logic        rd_req_valid,
    input  logic        rd_req_ready,
    output logic [39:0] rd_req_addr,
    output logic [9:0]  rd_req_len,
    output logic [7:0]  rd_req_tag,
    input  logic        cpl_done,
    input  logic [7:0]  cpl_tag,
    output logic        done,
    output logic [5:0]  outstanding
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_SGL = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_ADVANCE  = 3'd4;
    localparam logic [2:0] ST_FETCH    = 3'd5;
    localparam logic [2:0] ST_DRAIN    = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam int           PTR_W    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam logic [10:0]  MRRS_L   = 11'(MRRS_DW);
    localparam logic [5:0]   TAGS_L   = 6'(NUM_TAGS);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_TAGS - 1);
    // FETCH occupies ENTRY_LAT-1 cycles so that LOAD lands exactly ENTRY_LAT
    // cycles after the next_entry pulse issued in ADVANCE.
    localparam logic [7:0]   LAT_INIT = 8'((ENTRY_LAT > 1) ? ENTRY_LAT - 1 : 1);

    logic [2:0]       state_q, state_d;
    logic [39:0]      cur_addr_q, cur_addr_d;
    logic [9:0]       remain_q, remain_d;
    logic             is_last_q, is_last_d;
    logic [7:0]       lat_q, lat_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [5:0]       outst_q, outst_d;

    logic [10:0] to_4k;
    logic [10:0] chunk_m;
    logic [10:0] chunk;
    logic        can_issue;
    logic        req_vld;
    logic        xfer;
    logic        tag_in_range;
    logic        retire;

    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^sgl_dma_addr[1:0];

    // DWs left before the next 4 KB boundary: 1..1024 since cur_addr is DW aligned.
    assign to_4k   = 11'd1024 - {1'b0, cur_addr_q[11:2]};
    assign chunk_m = ({1'b0, remain_q} < MRRS_L) ? {1'b0, remain_q} : MRRS_L;
    assign chunk   = (chunk_m < to_4k) ? chunk_m : to_4k;

    assign can_issue = (outst_q < TAGS_L);
    assign req_vld   = (state_q == ST_ISSUE) && can_issue;
    assign xfer      = req_vld && rd_req_ready;

    assign tag_in_range = (cpl_tag >= TAG_BASE) &&
                          ({1'b0, cpl_tag} < ({1'b0, TAG_BASE} + 9'(NUM_TAGS)));
    // A completion with nothing in flight is spurious and must not underflow.
    assign retire = cpl_done && tag_in_range && (outst_q != 6'd0);

    // Request fields are forced to zero when not valid so the bus idles at 0;
    // while valid they only change on a transfer, which keeps them stable under backpressure.
    assign rd_req_valid = req_vld;
    assign rd_req_addr  = req_vld ? cur_addr_q : 40'd0;
    assign rd_req_len   = req_vld ? chunk[9:0] : 10'd0;
    assign rd_req_tag   = req_vld ? (TAG_BASE + 8'(ptr_q)) : 8'd0;

    // An abort arriving in ADVANCE wins: the loader pointer must not move.
    assign next_entry  = (state_q == ST_ADVANCE) && !is_last_q && !abort;
    assign dma_en      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign outstanding = outst_q;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        is_last_d  = is_last_q;
        lat_d      = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_SGL;
                end
            end
            ST_WAIT_SGL: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (sgl_ready) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cur_addr_d = {sgl_dma_addr[39:2], 2'b00};
                remain_d   = sgl_dma_len;
                is_last_d  = last_entry;
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (sgl_dma_len == 10'd0) begin
                    state_d = ST_ADVANCE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    cur_addr_d = cur_addr_q + {27'd0, chunk, 2'b00};
                    remain_d   = remain_q - chunk[9:0];
                    if (remain_q == chunk[9:0]) begin
                        state_d = ST_ADVANCE;
                    end
                end
                // The handshake above still takes effect in an abort cycle.
                if (abort) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ADVANCE: begin
                if (abort || is_last_q) begin
                    state_d = ST_DRAIN;
                end else if (ENTRY_LAT <= 1) begin
                    state_d = ST_LOAD;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (lat_q <= 8'd1) begin
                    state_d = ST_LOAD;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            ST_DRAIN: begin
                if (outst_q == 6'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tag pointer rotates through NUM_TAGS slots; wrap explicitly so a
    // single-tag configuration stays at slot 0.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
        end
    end

    always_comb begin
        outst_d = outst_q;
        case ({xfer, retire})
            2'b10:   outst_d = outst_q + 6'd1;
            2'b01:   outst_d = outst_q - 6'd1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= 40'd0;
            remain_q   <= 10'd0;
            is_last_q  <= 1'b0;
            lat_q      <= 8'd0;
            ptr_q      <= '0;
            outst_q    <= 6'd0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            is_last_q  <= is_last_d;
            lat_q      <= lat_d;
            ptr_q      <= ptr_d;
            outst_q    <= outst_d;
        end
    end

endmodule

// File: tb/tb_dma_rd_sgl_scheduler.sv
// Purpose : scoreboard bench for dma_rd_sgl_scheduler with a cycle-exact SGL loader model.
// Latency : loader entry data is valid only in the single cycle ENTRY_LAT after next_entry.
// Backpr. : rd_req_ready and cpl_done are driven directly by the directed tests.
module tb_dma_rd_sgl_scheduler;

    localparam int ENTRY_LAT = 3;

    logic        trn_clk;
    logic        trn_reset_n;
    logic        start;
    logic        abort;
    logic        sgl_ready;
    logic [39:0] sgl_dma_addr;
    logic [9:0]  sgl_dma_len;
    logic        last_entry;
    logic        next_entry;
    logic        dma_en;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [39:0] rd_req_addr;
    logic [9:0]  rd_req_len;
    logic [7:0]  rd_req_tag;
    logic        cpl_done;
    logic [7:0]  cpl_tag;
    logic        done;
    logic [5:0]  outstanding;

    dma_rd_sgl_scheduler #(
        .MRRS_DW   (128),
        .TAG_BASE  (8'h10),
        .NUM_TAGS  (8),
        .ENTRY_LAT (ENTRY_LAT)
    ) dut (
        .trn_clk      (trn_clk),
        .trn_reset_n  (trn_reset_n),
        .start        (start),
        .abort        (abort),
        .sgl_ready    (sgl_ready),
        .sgl_dma_addr (sgl_dma_addr),
        .sgl_dma_len  (sgl_dma_len),
        .last_entry   (last_entry),
        .next_entry   (next_entry),
        .dma_en       (dma_en),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_req_tag   (rd_req_tag),
        .cpl_done     (cpl_done),
        .cpl_tag      (cpl_tag),
        .done         (done),
        .outstanding  (outstanding)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    int checks;
    int failures;
    int xfer_cnt;
    int done_cnt;
    int ne_cnt;

    logic [57:0] exp_q[$];
    logic [39:0] ent_addr[4];
    logic [9:0]  ent_len[4];
    logic        ent_last[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge trn_clk);
    endtask

    task automatic push(input logic [39:0] a, input logic [9:0] l, input logic [7:0] t);
        exp_q.push_back({a, l, t});
    endtask

    // Scoreboard monitor: sampled 1 time unit before each rising edge.
    task automatic monitor_loop();
        logic [57:0] got;
        logic [57:0] e;
        forever begin
            @(negedge trn_clk);
            #4;
            if (trn_reset_n && rd_req_valid && rd_req_ready) begin
                xfer_cnt++;
                got = {rd_req_addr, rd_req_len, rd_req_tag};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got addr=0x%0h len=%0d tag=0x%0h, required none",
                             rd_req_addr, rd_req_len, rd_req_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("req{addr,len,tag}", {6'd0, got}, {6'd0, e});
                end
            end
            if (trn_reset_n && done) done_cnt++;
        end
    endtask

    // SGL loader model: entry k>0 is presented only during the cycle ENTRY_LAT
    // after its next_entry pulse, and garbage otherwise.
    task automatic sgl_loop();
        int idx;
        int wcnt;
        idx  = 0;
        wcnt = -1;
        forever begin
            @(negedge trn_clk);
            if (!trn_reset_n) begin
                idx  = 0;
                wcnt = -1;
            end else if (next_entry) begin
                idx++;
                ne_cnt++;
                wcnt = ENTRY_LAT;
            end else if (wcnt >= 0) begin
                wcnt--;
            end
            if ((idx < 4) && (wcnt == 0 || (wcnt < 0 && idx == 0))) begin
                sgl_dma_addr = ent_addr[idx];
                sgl_dma_len  = ent_len[idx];
                last_entry   = ent_last[idx];
            end else begin
                sgl_dma_addr = 40'hAB_CDEF_0000;
                sgl_dma_len  = 10'h3FF;
                last_entry   = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        trn_reset_n  = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        sgl_ready    = 1'b0;
        rd_req_ready = 1'b0;
        cpl_done     = 1'b0;
        cpl_tag      = 8'd0;
        tick(2);
        trn_reset_n = 1'b1;
        tick(1);
    endtask

    task automatic start_walk();
        start     = 1'b1;
        sgl_ready = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic retire(input logic [7:0] t);
        cpl_tag  = t;
        cpl_done = 1'b1;
        tick(1);
        cpl_done = 1'b0;
    endtask

    task automatic wait_xfers(input int base, input int n, input string name);
        int k;
        k = 0;
        while ((xfer_cnt - base) < n && k < 200) begin
            tick(1);
            k++;
        end
        chk(name, 64'(xfer_cnt - base), 64'(n));
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!rd_req_valid && k < 50) begin
            tick(1);
            k++;
        end
        chk(name, 64'(rd_req_valid), 64'd1);
    endtask

    task automatic wait_done(input int base, input string name);
        int k;
        k = 0;
        while (done_cnt == base && k < 200) begin
            tick(1);
            k++;
        end
        chk(name, 64'(done_cnt - base), 64'd1);
    endtask

    task automatic set_ent(input int i, input logic [39:0] a, input logic [9:0] l, input logic last);
        ent_addr[i] = a;
        ent_len[i]  = l;
        ent_last[i] = last;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dma_en"},      64'(dma_en),       64'd0);
        chk({tag, "_valid"},       64'(rd_req_valid), 64'd0);
        chk({tag, "_next_entry"},  64'(next_entry),   64'd0);
        chk({tag, "_done"},        64'(done),         64'd0);
        chk({tag, "_outstanding"}, 64'(outstanding),  64'd0);
        chk({tag, "_addr"},        64'(rd_req_addr),  64'd0);
        chk({tag, "_len"},         64'(rd_req_len),   64'd0);
        chk({tag, "_tag"},         64'(rd_req_tag),   64'd0);
    endtask

    initial begin
        int xb;
        int db;
        int nb;
        checks   = 0;
        failures = 0;
        xfer_cnt = 0;
        done_cnt = 0;
        ne_cnt   = 0;
        for (int i = 0; i < 4; i++) set_ent(i, 40'd0, 10'd0, 1'b1);
        trn_reset_n  = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        sgl_ready    = 1'b0;
        rd_req_ready = 1'b0;
        cpl_done     = 1'b0;
        cpl_tag      = 8'd0;
        sgl_dma_addr = 40'd0;
        sgl_dma_len  = 10'd0;
        last_entry   = 1'b0;
        fork
            monitor_loop();
            sgl_loop();
        join_none

        // Reset state
        tick(2);
        chk_all_zero("reset");
        do_reset();

        // Single entry split by MRRS
        set_ent(0, 40'h1000, 10'd300, 1'b1);
        push(40'h1000, 10'd128, 8'h10);
        push(40'h1200, 10'd128, 8'h11);
        push(40'h1400, 10'd44,  8'h12);
        xb = xfer_cnt; db = done_cnt; nb = ne_cnt;
        rd_req_ready = 1'b1;
        start_walk();
        wait_xfers(xb, 3, "t1_xfers");
        tick(3);
        chk("t1_outstanding", 64'(outstanding), 64'd3);
        chk("t1_dma_en", 64'(dma_en), 64'd1);
        chk("t1_no_done_yet", 64'(done_cnt - db), 64'd0);
        retire(8'h11); retire(8'h10); retire(8'h12);
        wait_done(db, "t1_done");
        tick(1);
        chk("t1_dma_en_off", 64'(dma_en), 64'd0);
        chk("t1_next_entry", 64'(ne_cnt - nb), 64'd0);
        do_reset();

        // 4 KB boundary split
        set_ent(0, 40'h0FF0, 10'd16, 1'b1);
        push(40'h0FF0, 10'd4,  8'h10);
        push(40'h1000, 10'd12, 8'h11);
        xb = xfer_cnt; db = done_cnt;
        rd_req_ready = 1'b1;
        start_walk();
        wait_xfers(xb, 2, "t2_xfers");
        retire(8'h10); retire(8'h11);
        wait_done(db, "t2_done");
        do_reset();

        // Three entries, middle empty, last with unaligned address bits
        set_ent(0, 40'h2000, 10'd8, 1'b0);
        set_ent(1, 40'h3000, 10'd0, 1'b0);
        set_ent(2, 40'h4003, 10'd4, 1'b1);
        push(40'h2000, 10'd8, 8'h10);
        push(40'h4000, 10'd4, 8'h11);
        xb = xfer_cnt; db = done_cnt; nb = ne_cnt;
        rd_req_ready = 1'b1;
        start_walk();
        wait_xfers(xb, 2, "t3_xfers");
        tick(3);
        chk("t3_next_entry", 64'(ne_cnt - nb), 64'd2);
        retire(8'h10); retire(8'h11);
        wait_done(db, "t3_done");
        chk("t3_next_entry_final", 64'(ne_cnt - nb), 64'd2);
        do_reset();

        // Tag exhaustion and wrap
        set_ent(0, 40'h10FFC, 10'd1000, 1'b1);
        push(40'h10FFC, 10'd1, 8'h10);
        for (int i = 0; i < 7; i++)
            push(40'h11000 + 40'(i * 512), 10'd128, 8'h11 + 8'(i));
        push(40'h11E00, 10'd103, 8'h10);
        xb = xfer_cnt; db = done_cnt;
        rd_req_ready = 1'b1;
        start_walk();
        wait_xfers(xb, 8, "t4_first8");
        tick(10);
        chk("t4_valid_blocked", 64'(rd_req_valid), 64'd0);
        chk("t4_outstanding_full", 64'(outstanding), 64'd8);
        chk("t4_no_ninth", 64'(xfer_cnt - xb), 64'd8);
        retire(8'h13);
        tick(5);
        chk("t4_one_more", 64'(xfer_cnt - xb), 64'd9);
        chk("t4_outstanding_refill", 64'(outstanding), 64'd8);
        for (int i = 0; i < 8; i++) retire(8'h10 + 8'(i));
        wait_done(db, "t4_done");
        do_reset();

        // Backpressure stability, out-of-range tags, simultaneous xfer+retire
        set_ent(0, 40'h20000, 10'd200, 1'b1);
        push(40'h20000, 10'd128, 8'h10);
        push(40'h20200, 10'd72,  8'h11);
        xb = xfer_cnt; db = done_cnt;
        rd_req_ready = 1'b0;
        start_walk();
        wait_valid("t5_valid_up");
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t5_hold_valid", 64'(rd_req_valid), 64'd1);
            chk("t5_hold_addr",  64'(rd_req_addr),  64'h20000);
            chk("t5_hold_len",   64'(rd_req_len),   64'd128);
            chk("t5_hold_tag",   64'(rd_req_tag),   64'h10);
        end
        rd_req_ready = 1'b1;
        tick(1);
        rd_req_ready = 1'b0;
        chk("t5_outstanding_1", 64'(outstanding), 64'd1);
        retire(8'h18);
        chk("t5_tag_above_range", 64'(outstanding), 64'd1);
        retire(8'h0F);
        chk("t5_tag_below_range", 64'(outstanding), 64'd1);
        rd_req_ready = 1'b1;
        cpl_tag      = 8'h10;
        cpl_done     = 1'b1;
        tick(1);
        rd_req_ready = 1'b0;
        cpl_done     = 1'b0;
        chk("t5_simul_unchanged", 64'(outstanding), 64'd1);
        chk("t5_xfers", 64'(xfer_cnt - xb), 64'd2);
        retire(8'h11);
        wait_done(db, "t5_done");
        tick(1);
        retire(8'h10);
        chk("t5_no_underflow", 64'(outstanding), 64'd0);
        do_reset();

        // Abort mid-ISSUE; third transfer coincides with abort
        set_ent(0, 40'h30000, 10'd1000, 1'b0);
        set_ent(1, 40'h50000, 10'd8, 1'b1);
        push(40'h30000, 10'd128, 8'h10);
        push(40'h30200, 10'd128, 8'h11);
        push(40'h30400, 10'd128, 8'h12);
        xb = xfer_cnt; db = done_cnt; nb = ne_cnt;
        rd_req_ready = 1'b0;
        start_walk();
        wait_valid("t6_valid_up");
        for (int i = 0; i < 2; i++) begin
            rd_req_ready = 1'b1;
            tick(1);
            rd_req_ready = 1'b0;
        end
        rd_req_ready = 1'b1;
        abort        = 1'b1;
        tick(1);
        abort        = 1'b0;
        chk("t6_outstanding_3", 64'(outstanding), 64'd3);
        tick(20);
        chk("t6_no_more_reqs", 64'(xfer_cnt - xb), 64'd3);
        chk("t6_no_next_entry", 64'(ne_cnt - nb), 64'd0);
        chk("t6_valid_low", 64'(rd_req_valid), 64'd0);
        chk("t6_dma_en_drain", 64'(dma_en), 64'd1);
        retire(8'h12); retire(8'h10);
        chk("t6_not_done_early", 64'(done_cnt - db), 64'd0);
        cpl_tag  = 8'h11;
        cpl_done = 1'b1;
        tick(1);
        cpl_done = 1'b0;
        chk("t6_done_not_yet", 64'(done), 64'd0);
        chk("t6_outstanding_0", 64'(outstanding), 64'd0);
        tick(1);
        chk("t6_done_pulse", 64'(done), 64'd1);
        tick(1);
        chk("t6_done_single", 64'(done), 64'd0);
        chk("t6_dma_en_off", 64'(dma_en), 64'd0);

        // Asynchronous reset mid-walk
        set_ent(0, 40'h40000, 10'd1000, 1'b0);
        push(40'h40000, 10'd128, 8'h13);
        push(40'h40200, 10'd128, 8'h14);
        xb = xfer_cnt;
        rd_req_ready = 1'b0;
        start_walk();
        wait_valid("t7_valid_up");
        for (int i = 0; i < 2; i++) begin
            rd_req_ready = 1'b1;
            tick(1);
            rd_req_ready = 1'b0;
        end
        chk("t7_outstanding_2", 64'(outstanding), 64'd2);
        #2;
        trn_reset_n = 1'b0;
        #1;
        chk_all_zero("t7_async_reset");
        tick(1);
        trn_reset_n = 1'b1;
        tick(2);
        chk("t7_idle_after_reset", 64'(dma_en), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
